// File: rtl/spi_wb_master.sv
`timescale 1ns/1ps
// spi_wb_master
// SPI (mode 0) slave front end that turns each chip-select frame into exactly
// one wishbone read or write on the register bus.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi  : SPI inputs, asynchronous to clk (synchronised here)
//   spi_miso            : read data back to the host, MSB first
//   wb_*                : wishbone master (7-bit address, 32-bit data)
//   busy                : high while a wishbone cycle is outstanding
// Frame: byte0 = {W, A[6:0]}; write = 4 data bytes; read = 1 dummy byte
// followed by 4 response bytes on MISO.
module spi_wb_master #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, WBUSY, RWAIT, RDATA, DONE} state_t;

    // ---------------- input synchronisers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
    logic sclk_prev_reg, cs_prev_reg;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // cs_n chain resets to the inactive level so reset release never looks
    // like the start of a frame by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_fall   = ~cs_s & cs_prev_reg;
    assign cs_rise   = cs_s & ~cs_prev_reg;

    // ---------------- state and datapath registers ----------------
    state_t             state_reg, state_next;
    logic [5:0]         bit_cnt_reg, bit_cnt_next;     // rising edges in frame, saturating
    logic [DATA_W-2:0]  shift_reg, shift_next;         // MOSI history (newest bit is mosi_s)
    logic [DATA_W-1:0]  rd_shift_reg, rd_shift_next;   // MISO response shifter
    logic               rd_got_reg, rd_got_next;       // read ack arrived in time
    logic               miso_reg, miso_next;
    logic               cyc_reg, cyc_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  adr_reg, adr_next;
    logic [DATA_W-1:0]  dat_reg, dat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            rd_shift_reg <= '0;
            rd_got_reg   <= 1'b0;
            miso_reg     <= 1'b0;
            cyc_reg      <= 1'b0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            rd_shift_reg <= rd_shift_next;
            rd_got_reg   <= rd_got_next;
            miso_reg     <= miso_next;
            cyc_reg      <= cyc_next;
            we_reg       <= we_next;
            adr_reg      <= adr_next;
            dat_reg      <= dat_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        rd_shift_next = rd_shift_reg;
        rd_got_next   = rd_got_reg;
        miso_next     = miso_reg;
        cyc_next      = cyc_reg;
        we_next       = we_reg;
        adr_next      = adr_reg;
        dat_next      = dat_reg;

        // The bus cycle lives independently of the SPI side: once raised it
        // is only dropped by ack (or reset), even if the frame is aborted.
        // Read data is only kept if it arrives before MISO needs bit 31.
        if (cyc_reg && wb_ack_i) begin
            cyc_next = 1'b0;
            if (!we_reg && state_reg == RWAIT) begin
                rd_shift_next = wb_dat_i;
                rd_got_next   = 1'b1;
            end
        end

        if (sclk_rise && (state_reg == CMD || state_reg == WDATA || state_reg == RWAIT ||
                          state_reg == RDATA) && bit_cnt_reg != 6'h3F)
            bit_cnt_next = bit_cnt_reg + 6'd1;

        if (sclk_rise && (state_reg == CMD || state_reg == WDATA))
            shift_next = {shift_reg[DATA_W-3:0], mosi_s};

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_next = '0;
                    shift_next   = '0;
                    rd_got_next  = 1'b0;
                    // A frame that starts while the previous cycle is still
                    // outstanding is swallowed whole.
                    state_next   = cyc_reg ? DONE : CMD;
                end
            end
            CMD: begin
                if (sclk_rise && bit_cnt_reg == 6'd7) begin
                    we_next  = shift_reg[6];
                    adr_next = {shift_reg[5:0], mosi_s};
                    if (shift_reg[6]) begin
                        state_next = WDATA;
                    end else begin
                        cyc_next   = 1'b1;
                        state_next = RWAIT;
                    end
                end
            end
            WDATA: begin
                if (sclk_rise && bit_cnt_reg == 6'd39) begin
                    dat_next   = {shift_reg, mosi_s};
                    cyc_next   = 1'b1;
                    state_next = WBUSY;
                end
            end
            WBUSY: begin
                if (cyc_reg && wb_ack_i)
                    state_next = DONE;
            end
            RWAIT: begin
                // Last falling edge of the dummy byte: bit 31 must go out now.
                if (sclk_fall && bit_cnt_reg == 6'd16) begin
                    state_next = RDATA;
                    if (rd_got_reg) begin
                        miso_next = rd_shift_reg[DATA_W-1];
                    end else if (cyc_reg && wb_ack_i) begin
                        miso_next = wb_dat_i[DATA_W-1];
                    end else begin
                        rd_shift_next = '1;
                        miso_next     = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (sclk_fall) begin
                    if (bit_cnt_reg >= 6'd48) begin
                        state_next = DONE;
                        miso_next  = 1'b0;
                    end else begin
                        miso_next     = rd_shift_reg[DATA_W-2];
                        rd_shift_next = {rd_shift_reg[DATA_W-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                miso_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        if (cs_rise) begin
            state_next = IDLE;
            miso_next  = 1'b0;
        end
    end

    assign spi_miso = (state_reg == RDATA) & miso_reg;
    assign wb_stb_o = cyc_reg;
    assign wb_cyc_o = cyc_reg;
    assign busy     = cyc_reg;
    assign wb_we_o  = we_reg;
    assign wb_adr_o = adr_reg;
    assign wb_dat_o = dat_reg;

endmodule

// File: tb/tb_spi_wb_master.sv
`timescale 1ns/1ps
module tb_spi_wb_master;
    localparam int HALF = 4;   // sclk half period in clk cycles (sclk = clk/8)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        wb_stb_o, wb_cyc_o, wb_we_o, busy;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int ack_delay = 1;
    logic [31:0] rd_data = 32'h0;

    typedef struct packed {
        logic        we;
        logic [6:0]  adr;
        logic [31:0] dat;
    } wb_txn_t;
    wb_txn_t exp_q[$];

    always #5 clk = ~clk;

    spi_wb_master #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // SPI host, mode 0. MOSI bits are taken MSB-first from tx[47:..]; every
    // complete received byte is compared against the matching byte of exp_rx.
    task automatic spi_xfer(input string name, input int nbits, input logic [47:0] tx,
                            input logic [47:0] exp_rx);
        logic [7:0] rx_byte;
        rx_byte = 8'h0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[47-i];
            repeat (HALF) @(negedge clk);
            rx_byte = {rx_byte[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
            if (i % 8 == 7)
                check($sformatf("%s_miso_byte%0d", name, i / 8), {56'h0, rx_byte},
                      {56'h0, exp_rx[47-8*(i/8) -: 8]});
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
        check({name, "_busy_clear"}, {63'h0, busy}, 64'h0);
    endtask

    // Wishbone slave: acks ack_delay cycles after seeing stb, unless the
    // cycle vanished in the meantime (reset).
    initial begin
        forever begin
            int d;
            @(posedge clk); #1;
            if (rst_n && wb_stb_o) begin
                d = ack_delay;
                for (int k = 0; k < d; k++) begin
                    @(posedge clk); #1;
                end
                if (rst_n && wb_stb_o) begin
                    wb_dat_i = wb_we_o ? 32'h0 : rd_data;
                    wb_ack_i = 1'b1;
                    @(posedge clk); #1;
                    wb_ack_i = 1'b0;
                    wb_dat_i = 32'h0;
                end
            end
        end
    end

    // Scoreboard monitor: every new stb is one transaction matched against
    // the expected queue; stb must hold until ack and drop right after it.
    logic stb_prev = 1'b0;
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        wb_txn_t e;
        if (!rst_n) begin
            stb_prev = 1'b0;
            ack_prev = 1'b0;
        end else begin
            if (stb_prev && ack_prev)
                check("stb_drop_after_ack", {63'h0, wb_stb_o}, 64'h0);
            else if (stb_prev && !wb_stb_o) begin
                checks++;
                failures++;
                $display("FAIL stb_held_until_ack actual=0 required=1");
            end
            if (wb_stb_o && !stb_prev) begin
                check("cyc_busy_eq_stb", {62'h0, wb_cyc_o, busy}, 64'h3);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected_cycle actual we=%0b adr=0x%0h required=no cycle",
                             wb_we_o, wb_adr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_we", {63'h0, wb_we_o}, {63'h0, e.we});
                    check("wb_adr", {57'h0, wb_adr_o}, {57'h0, e.adr});
                    if (e.we)
                        check("wb_dat", {32'h0, wb_dat_o}, {32'h0, e.dat});
                end
            end
            stb_prev = wb_stb_o;
            ack_prev = wb_ack_i;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {23'h0, spi_miso, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, busy}, 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_outputs", {23'h0, spi_miso, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, busy}, 64'h0);

        // Write 0x13 <= 0xDEADBEEF, quick ack
        ack_delay = 1;
        exp_q.push_back({1'b1, 7'h13, 32'hDEADBEEF});
        spi_xfer("wr1", 40, {8'h93, 32'hDEADBEEF, 8'h00}, 48'h0);
        wait_idle("wr1");

        // Read 0x71, ack after 3 cycles with 0x12345678
        ack_delay = 3;
        rd_data = 32'h12345678;
        exp_q.push_back({1'b0, 7'h71, 32'h0});
        spi_xfer("rd1", 48, {8'h71, 40'h0}, 48'h0000_1234_5678);
        wait_idle("rd1");

        // Read with very late ack: all-ones response, late data discarded
        ack_delay = 200;
        rd_data = 32'hCAFEF00D;
        exp_q.push_back({1'b0, 7'h22, 32'h0});
        spi_xfer("rd_late", 48, {8'h22, 40'h0}, 48'h0000_FFFF_FFFF);
        wait_idle("rd_late");

        // Truncated write: no cycle; then a full write to 0x10
        spi_xfer("wr_short", 28, {8'h90, 20'hABCDE, 20'h0}, 48'h0);
        ack_delay = 1;
        exp_q.push_back({1'b1, 7'h10, 32'h00000001});
        spi_xfer("wr_10", 40, {8'h90, 32'h00000001, 8'h00}, 48'h0);
        wait_idle("wr_10");

        // Write with ack withheld 50 cycles; a frame issued while busy is ignored
        ack_delay = 50;
        exp_q.push_back({1'b1, 7'h2A, 32'h0F0F1234});
        spi_xfer("wr_hold", 40, {8'hAA, 32'h0F0F1234, 8'h00}, 48'h0);
        check("busy_while_ack_withheld", {63'h0, busy}, 64'h1);
        spi_xfer("ignored", 48, {8'h05, 40'h0}, 48'h0);
        wait_idle("wr_hold");

        // Asynchronous reset in the middle of a read with stb high
        ack_delay = 50;
        exp_q.push_back({1'b0, 7'h33, 32'h0});
        fork
            spi_xfer("rd_rst", 10, {8'h33, 40'h0}, 48'h0);
            begin
                for (int k = 0; k < 500 && !wb_stb_o; k++) @(negedge clk);
                check("rd_rst_stb_seen", {63'h0, wb_stb_o}, 64'h1);
                #2 rst_n = 1'b0;
                #1 check("async_reset_outputs",
                         {23'h0, spi_miso, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, busy}, 64'h0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        ack_delay = 2;
        rd_data = 32'hA5C30F96;
        exp_q.push_back({1'b0, 7'h7F, 32'h0});
        spi_xfer("rd_7f", 48, {8'h7F, 40'h0}, 48'h0000_A5C3_0F96);
        wait_idle("rd_7f");

        repeat (10) @(negedge clk);
        check("exp_queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_wb_master.md
Name: spi_wb_master

Overview:
SPI slave front end and single wishbone master for the register bus. Each chip-select frame from the external host is decoded into one wishbone read or write. The block drives the bus dispatcher's requester port (7-bit address, 32-bit data). Read data is returned on MISO within the same frame.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on spi_sclk, spi_cs_n and spi_mosi (minimum 2)
ADDR_W, 7, wishbone address width; must be 7
DATA_W, 32, wishbone data width; must be 32

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
spi_cs_n  input  1  SPI chip select, active low, frames one transaction
spi_mosi  input  1  host-to-device serial data, MSB first
spi_miso  output  1  device-to-host serial data, MSB first
wb_stb_o  output  1  wishbone strobe
wb_cyc_o  output  1  wishbone cycle; equals wb_stb_o
wb_we_o  output  1  wishbone write enable
wb_adr_o  output  7  wishbone address
wb_dat_o  output  32  wishbone write data
wb_dat_i  input  32  wishbone read data
wb_ack_i  input  1  wishbone acknowledge
busy  output  1  high while a wishbone cycle is outstanding

Behaviour:
- Reset: all outputs 0; state IDLE; shift registers and bit counters cleared. Reset is asynchronous; release is synchronous to clk.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on synchronised sclk. spi_sclk is limited to at most clk/8.
- Sampling: mosi is sampled on sclk rising edges. miso changes on sclk falling edges.
- Frame format: byte0 = {W, A[6:0]}, W=1 for write.
  - Write frame: 4 data bytes follow, MSB first.
  - Read frame: 1 dummy byte, then 4 response bytes on MISO.
- States:
  - IDLE: entered on the cs_n falling edge. Clears the bit counter and goes to CMD.
  - CMD: after 8 rising edges, latches wb_we_o=W and wb_adr_o=A.
    - W=1: go to WDATA.
    - W=0: assert stb/cyc and go to RWAIT.
  - WDATA: after 32 rising edges, loads wb_dat_o, asserts stb/cyc and goes to WBUSY.
  - WBUSY: holds stb/cyc/we/adr/dat stable until wb_ack_i; deasserts stb/cyc on the cycle after ack is seen; goes to DONE.
  - RWAIT: on wb_ack_i, captures wb_dat_i into the read shift register and deasserts stb/cyc the next cycle.
    - At the 8th falling edge of the dummy byte, miso presents bit 31.
    - If ack has not arrived by that falling edge, the response is 0xFFFFFFFF. The cycle is still held until ack and that late data is discarded.
    - Go to RDATA.
  - RDATA: shifts one bit per falling edge for 32 bits, then goes to DONE.
  - DONE: further sclk edges are ignored; miso=0.
- cs_n rising edge (any state): SPI side returns to IDLE and miso=0.
  - A wishbone cycle already asserted still completes: stb/cyc are held until ack, then dropped.
  - A write with fewer than 32 data bits issues no wishbone cycle.
  - A new cs_n falling edge while busy=1 is ignored; that frame is treated as DONE.
- busy = wb_cyc_o.
- Bit and byte counters never wrap within a frame. Excess bits go to DONE.
- miso is 0 whenever not in RDATA or when bit 31 is not being presented.
- wb_cyc_o/wb_stb_o never assert for more than one transaction per frame.

Test Plan:
- Write frame 0x93,0xDE,0xAD,0xBE,0xEF with ack 1 cycle after stb -> one wishbone cycle: we=1, adr=0x13, dat=0xDEADBEEF; stb high exactly until the cycle after ack; busy returns to 0.
- Read frame 0x71 + 5 bytes, slave acks with 0x12345678 after 3 cycles -> we=0, adr=0x71; MISO bytes 2-5 = 0x12,0x34,0x56,0x78; MISO=0 during bytes 0-1.
- Read with slave ack delayed 200 clk at sclk=clk/8 -> MISO returns 0xFFFFFFFF; stb held until ack; no second cycle issued.
- cs_n raised after 20 write-data bits -> no wishbone cycle; the next full write frame to 0x10 with 0x00000001 executes normally.
- cs_n raised during WBUSY with ack withheld 50 cycles -> stb/cyc stay high until ack, then drop; a frame started while busy is ignored.
- rst_n asserted mid-read with stb high -> all outputs 0 immediately (async); after release, a read frame to 0x7F completes correctly.
